// File: rtl/traffic_pkg.sv
// Shared constants for the traffic-light controller: button polarity, light colour
// encodings and default timing for the button front end.
package traffic_pkg;

  localparam logic BTN_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    GREEN = 2'b01,
    AMBER = 2'b10,
    RED   = 2'b11
  } color_t;

  localparam int DEB_CYCLES_DEF  = 50000;
  localparam int LOCK_CYCLES_DEF = 1000000;

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-FF synchroniser, stable-level debouncer and press (1->0) detector.
// press is high for exactly one cycle after the debounced level falls.
module btn_debounce
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES);

  logic [1:0]    sync_q;
  logic          stable_q;
  logic          stable_d_q;
  logic [CW-1:0] cnt_q;
  logic          sync_out;

  assign sync_out = sync_q[1];

  // NOTE: every state element here uses non-blocking assignment so all flops
  // update from pre-edge values, giving a true shift chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= 2'b11;
      stable_q   <= 1'b1;
      stable_d_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      sync_q     <= {sync_q[0], raw};
      stable_d_q <= stable_q;
      if (sync_out == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        // DEB_CYCLES consecutive differing samples: accept the new level
        stable_q <= sync_out;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press = (stable_d_q != BTN_ACTIVE) && (stable_q == BTN_ACTIVE);

endmodule

// File: rtl/button_conditioner.sv
// Conditions the two active-low request buttons into one-cycle active-low pulses for
// the semaphore FSM, with botao1 priority. Optional lockout: define BTN_LOCKOUT_EN.
module button_conditioner
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn1_raw,
  input  logic btn2_raw,
  output logic botao1,
  output logic botao2,
  output logic busy
);

  logic press1;
  logic press2;
  logic pulse1;
  logic pulse2;
  logic blocked;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn1 (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn1_raw),
    .press (press1)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn2 (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn2_raw),
    .press (press2)
  );

`ifdef BTN_LOCKOUT_EN
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  logic [LW-1:0] lock_q;

  // Loaded the cycle after a pulse, so the pulse cycle itself is never busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= '0;
    end else if (botao1 == BTN_ACTIVE || botao2 == BTN_ACTIVE) begin
      lock_q <= LW'(LOCK_CYCLES);
    end else if (lock_q != '0) begin
      lock_q <= lock_q - LW'(1);
    end
  end

  assign busy    = (lock_q != '0);
  assign blocked = busy;
`else
  assign busy    = 1'b0;
  assign blocked = 1'b0;
`endif

  // NOTE: outputs of a combinational block get a default first so no path
  // leaves them unassigned, which would otherwise infer a latch.
  always_comb begin
    pulse1 = 1'b0;
    pulse2 = 1'b0;
    if (!blocked) begin
      pulse1 = press1;
      pulse2 = press2 && !press1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      botao1 <= ~BTN_ACTIVE;
      botao2 <= ~BTN_ACTIVE;
    end else begin
      botao1 <= pulse1 ? BTN_ACTIVE : ~BTN_ACTIVE;
      botao2 <= pulse2 ? BTN_ACTIVE : ~BTN_ACTIVE;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner (DEB_CYCLES=4, LOCK_CYCLES=16); expectations adapt to
// BTN_LOCKOUT_EN. Expected pulses are queued when stimulus is driven and consumed per edge.
module tb_button_conditioner;

  localparam int DEB  = 4;
  localparam int LOCK = 16;
  localparam int LAT  = DEB + 3;

  typedef struct {
    int at_edge;
    int ch;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn1_raw = 1'b0;
  logic btn2_raw = 1'b1;
  logic botao1;
  logic botao2;
  logic busy;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_n = 0;
  int   lock_exp = 0;
  bit   pulse_prev = 1'b0;
  logic e1, e2, e_busy;

  button_conditioner #(.DEB_CYCLES(DEB), .LOCK_CYCLES(LOCK)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn1_raw (btn1_raw),
    .btn2_raw (btn2_raw),
    .botao1   (botao1),
    .botao2   (botao2),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic expect_pulse(input int ch);
    exp_t e;
    e.at_edge = edge_n + LAT;
    e.ch      = ch;
    sb.push_back(e);
  endtask

  // Advance one rising edge, derive expected outputs for it, return at the falling edge.
  task automatic tick();
    @(posedge clk);
    edge_n++;
    e1 = 1'b1;
    e2 = 1'b1;
    if (rst) begin
      lock_exp   = 0;
      pulse_prev = 1'b0;
      sb.delete();
    end else begin
`ifdef BTN_LOCKOUT_EN
      if (lock_exp > 0) lock_exp--;
      if (pulse_prev) lock_exp = LOCK;
`endif
      while (sb.size() > 0 && sb[0].at_edge < edge_n) void'(sb.pop_front());
      if (sb.size() > 0 && sb[0].at_edge == edge_n) begin
        if (sb[0].ch == 1) e1 = 1'b0;
        else e2 = 1'b0;
        void'(sb.pop_front());
      end
      pulse_prev = !e1 || !e2;
    end
    e_busy = (lock_exp != 0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 40; i++) begin
      if (i == 3) begin
        rst = 1'b0;
        expect_pulse(1);
      end
      if (i == 15) btn1_raw = 1'b1;
      tick();
      n_cmp++;
      if ({botao1, botao2, busy} !== {e1, e2, e_busy}) begin
        n_bad++;
        $display("FAIL reset edge=%0d got b1/b2/busy=%b%b%b want %b%b%b",
                 edge_n, botao1, botao2, busy, e1, e2, e_busy);
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL reset_pending got %0d unconsumed pulses want 0", sb.size());
    end
  endtask

  task automatic test_press();
    for (int i = 0; i < 45; i++) begin
      if (i == 0) begin
        btn1_raw = 1'b0;
        expect_pulse(1);
      end
      if (i == 20) btn1_raw = 1'b1;
      tick();
      n_cmp++;
      if ({botao1, botao2, busy} !== {e1, e2, e_busy}) begin
        n_bad++;
        $display("FAIL press edge=%0d got b1/b2/busy=%b%b%b want %b%b%b",
                 edge_n, botao1, botao2, busy, e1, e2, e_busy);
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL press_pending got %0d unconsumed pulses want 0", sb.size());
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 65; i++) begin
      if (i < 20 && i % 2 == 0) btn2_raw = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      if (i == 20) begin
        btn2_raw = 1'b0;
        expect_pulse(2);
      end
      if (i == 40) btn2_raw = 1'b1;
      tick();
      n_cmp++;
      if ({botao1, botao2, busy} !== {e1, e2, e_busy}) begin
        n_bad++;
        $display("FAIL bounce edge=%0d got b1/b2/busy=%b%b%b want %b%b%b",
                 edge_n, botao1, botao2, busy, e1, e2, e_busy);
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL bounce_pending got %0d unconsumed pulses want 0", sb.size());
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 40; i++) begin
      if (i == 0) begin
        btn1_raw = 1'b0;
        btn2_raw = 1'b0;
        expect_pulse(1);
      end
      if (i == 20) begin
        btn1_raw = 1'b1;
        btn2_raw = 1'b1;
      end
      tick();
      n_cmp++;
      if ({botao1, botao2, busy} !== {e1, e2, e_busy}) begin
        n_bad++;
        $display("FAIL simultaneous edge=%0d got b1/b2/busy=%b%b%b want %b%b%b",
                 edge_n, botao1, botao2, busy, e1, e2, e_busy);
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL simultaneous_pending got %0d unconsumed pulses want 0", sb.size());
    end
  endtask

  task automatic test_lockout();
    for (int i = 0; i < 85; i++) begin
      if (i == 0) begin
        btn1_raw = 1'b0;
        expect_pulse(1);
      end
      if (i == 3) begin
        btn2_raw = 1'b0;
`ifndef BTN_LOCKOUT_EN
        expect_pulse(2);
`endif
      end
      if (i == 30) begin
        btn1_raw = 1'b1;
        btn2_raw = 1'b1;
      end
      if (i == 40) begin
        btn2_raw = 1'b0;
        expect_pulse(2);
      end
      if (i == 60) btn2_raw = 1'b1;
      tick();
      n_cmp++;
      if ({botao1, botao2, busy} !== {e1, e2, e_busy}) begin
        n_bad++;
        $display("FAIL lockout edge=%0d got b1/b2/busy=%b%b%b want %b%b%b",
                 edge_n, botao1, botao2, busy, e1, e2, e_busy);
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL lockout_pending got %0d unconsumed pulses want 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 55; i++) begin
      if (i == 0) begin
        btn1_raw = 1'b0;
        expect_pulse(1);
      end
      if (i == 10) rst = 1'b1;
      if (i == 11) begin
        rst = 1'b0;
        expect_pulse(1);
      end
      if (i == 30) btn1_raw = 1'b1;
      tick();
      n_cmp++;
      if ({botao1, botao2, busy} !== {e1, e2, e_busy}) begin
        n_bad++;
        $display("FAIL reset_mid edge=%0d got b1/b2/busy=%b%b%b want %b%b%b",
                 edge_n, botao1, botao2, busy, e1, e2, e_busy);
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL reset_mid_pending got %0d unconsumed pulses want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_simultaneous();
    test_lockout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
